game_state_rx: RTL and testbench
================================

// Module: game_state_rx
// PURPOSE
//  Remote-board end of the game-state UART link: deserialises rx bytes and unpacks the 10-byte state packet.
//  The packet carries player-1 position, ball position, scores and flags; outputs drive the remote game/render path.
//  Outputs update atomically on a checksum-valid packet, with pkt_valid pulsed.
// PARAMETERS
//  CLK_HZ        65_000_000  core clock frequency (Hz)
//  BAUD          115_200     line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer div, 564)
//  TIMEOUT_CLKS  65_000      max idle clocks between bytes inside a packet (1 ms)
// PORTS
//  clk         in   1   core clock (clk65MHz domain)
//  rst_n       in   1   synchronous reset, active-low
//  rx          in   1   async UART line, idle high, 8N1, LSB first
//  pl1_posx    out  12  remote player x position
//  pl1_posy    out  12  remote player y position
//  ball_xpos   out  12  ball x position
//  ball_ypos   out  12  ball y position
//  score_pl1   out  4   player-1 score
//  score_pl2   out  4   player-2 score
//  endgame     out  1   end-of-game flag (level)
//  last_touch  out  1   last-touch flag (level)
//  whistle_play out 1   1-cycle pulse: valid packet with whistle bit set
//  pkt_valid   out  1   1-cycle pulse: packet accepted
//  pkt_err     out  1   1-cycle pulse: checksum, framing or timeout error
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all outputs 0, both FSMs idle/HUNT, counters 0, rx sync regs = 1.
//  Byte RX: rx through 2-FF synchronizer. IDLE -> START on synced falling edge.
//   START: at CLKS_PER_BIT/2 recheck rx; 0 -> DATA, 1 -> IDLE (glitch, no error).
//   DATA: 8 samples every CLKS_PER_BIT, LSB first. STOP: sample after CLKS_PER_BIT.
//   Stop=1 -> byte_valid pulse. Stop=0 -> frame_err pulse and byte dropped. Either way -> IDLE (back-to-back ok).
//  Packet byte order:
//   B0=0xA5 header; B1=pl1_posx[11:4]; B2={pl1_posx[3:0],pl1_posy[11:8]}; B3=pl1_posy[7:0];
//   B4..B6 same layout for ball_xpos/ball_ypos; B7={score_pl1,score_pl2};
//   B8={5'b0,endgame,whistle,last_touch}; B9=XOR of B1..B8.
//  Packet FSM: HUNT -> PAYLOAD (idx 1..8, shadow regs + running XOR) -> CHECK.
//   HUNT: non-0xA5 bytes ignored, no error.
//   PAYLOAD: 0xA5 is ordinary data (no resync).
//   CHECK: B9==xor -> copy shadow to outputs, pkt_valid=1, whistle_play=B8[1], all in the cycle after
//    B9 byte_valid; else pkt_err=1, outputs hold. Both -> HUNT.
//  Outputs change only on an accepted packet; partial packets never reach outputs.
//  Timeout: in PAYLOAD/CHECK, gap counter counts from each byte_valid; reaching TIMEOUT_CLKS -> pkt_err, HUNT.
//  frame_err while outside HUNT -> pkt_err, HUNT. frame_err in HUNT -> no pkt_err.
//  Reset mid-packet: shadow discarded, outputs to 0, HUNT.
//  pkt_valid and pkt_err never both high. Latency from B9 stop-bit sample to pkt_valid = 1 clk.
// STRUCTURE
//  Package game_link_pkg: PKT_HEADER=8'hA5, PKT_LEN=10, flag bit indices (ENDGAME=2, WHISTLE=1, LAST_TOUCH=0),
//   shared with the transmit-side packer.
//  Sub-module uart_rx_byte (synchronizer + bit FSM; outputs byte_data[7:0], byte_valid, frame_err).
//  Packet FSM, shadow regs, XOR and timeout live in game_state_rx.
// TESTING
//  1 Packet pl1=(0x123,0x456), ball=(0x789,0xABC), scores 3/5, flags 3'b101, good xor
//    -> pkt_valid 1 clk; outputs exact; whistle_play 0; endgame=1; last_touch=1.
//  2 Same packet, flags 3'b010 -> whistle_play pulses with pkt_valid.
//    Next packet with whistle bit 0 -> no pulse.
//  3 Same packet with B9 xor^8'h01 -> pkt_err 1 clk, outputs hold previous values, next good packet accepted.
//  4 Garbage 0x00,0x5A then valid packet -> only that packet accepted, no pkt_err.
//    Payload containing 0xA5 (pl1_posx=0xA50) decodes correctly.
//  5 Send B0..B4, idle TIMEOUT_CLKS+10 -> pkt_err; following full packet accepted.
//    Stop bit forced 0 on B3 -> pkt_err, HUNT.
//  6 rst_n low during B5 -> all outputs 0; rest of interrupted packet ignored (no header);
//    fresh packet accepted. 1/4-bit low glitch on idle rx -> no byte.

Source files
------------

// File: rtl/game_link_pkg.sv
// Shared definitions for the game-state UART link (receiver here, packer on the transmit board).
// Holds packet framing constants, flag bit positions, FSM state types, the decoded state record
// and the payload unpacking helper used when a packet is accepted.
package game_link_pkg;

   localparam logic [7:0] PKT_HEADER = 8'hA5;
   localparam int PKT_LEN = 10;

   // Bit positions inside payload byte B8
   localparam int FLAG_ENDGAME    = 2;
   localparam int FLAG_WHISTLE    = 1;
   localparam int FLAG_LAST_TOUCH = 0;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {PK_HUNT, PK_PAYLOAD, PK_CHECK} pkt_state_t;

   typedef struct packed {
      logic [11:0] pl1_posx;
      logic [11:0] pl1_posy;
      logic [11:0] ball_xpos;
      logic [11:0] ball_ypos;
      logic [3:0]  score_pl1;
      logic [3:0]  score_pl2;
      logic        endgame;
      logic        last_touch;
   } game_state_t;

   // pl[0] holds B1 ... pl[7] holds B8
   function automatic game_state_t unpack_payload(input logic [7:0][7:0] pl);
      game_state_t s;
      s.pl1_posx   = {pl[0], pl[1][7:4]};
      s.pl1_posy   = {pl[1][3:0], pl[2]};
      s.ball_xpos  = {pl[3], pl[4][7:4]};
      s.ball_ypos  = {pl[4][3:0], pl[5]};
      s.score_pl1  = pl[6][7:4];
      s.score_pl2  = pl[6][3:0];
      s.endgame    = pl[7][FLAG_ENDGAME];
      s.last_touch = pl[7][FLAG_LAST_TOUCH];
      return s;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, falling-edge start detect, mid-bit sampling.
// Ports: clk, rst_n (sync, active-low), rx (async line) -> byte_data, byte_valid (1-cycle),
// frame_err (1-cycle, stop bit sampled low; byte dropped). No backpressure: bytes are pulses.
module uart_rx_byte
   import game_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 564
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic valid_q, valid_d;
   logic ferr_q, ferr_d;
   logic rx_meta_q, rx_sync_q, rx_prev_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            // Edge detect rather than level so a low line after a bad stop bit does not retrigger
            if (rx_prev_q && !rx_sync_q) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               bit_d = '0;
               state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = RX_STOP;
               else bit_d = bit_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               if (rx_sync_q) begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign byte_data  = data_q;
   assign byte_valid = valid_q;
   assign frame_err  = ferr_q;

endmodule

// File: rtl/game_state_rx.sv
// Remote-board game-state receiver: UART bytes -> 10-byte packet -> atomically updated outputs.
// Ports: clk, rst_n, rx in; player/ball positions, scores, flags, whistle_play/pkt_valid/pkt_err pulses out.
// Latency: pkt_valid one clock after the checksum byte's byte_valid. No backpressure: line-rate input.
module game_state_rx
   import game_link_pkg::*;
#(
   parameter int CLK_HZ       = 65_000_000,
   parameter int BAUD         = 115_200,
   parameter int TIMEOUT_CLKS = 65_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   output logic [11:0] pl1_posx,
   output logic [11:0] pl1_posy,
   output logic [11:0] ball_xpos,
   output logic [11:0] ball_ypos,
   output logic [3:0]  score_pl1,
   output logic [3:0]  score_pl2,
   output logic        endgame,
   output logic        last_touch,
   output logic        whistle_play,
   output logic        pkt_valid,
   output logic        pkt_err
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(TIMEOUT_CLKS - 1);

   logic [7:0] byte_data;
   logic byte_valid, frame_err;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   pkt_state_t state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0][7:0] shadow_q, shadow_d;
   logic [7:0] xor_q, xor_d;
   logic [TW-1:0] gap_q, gap_d;
   game_state_t outs_q, outs_d;
   logic valid_q, valid_d, err_q, err_d, whistle_q, whistle_d;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      xor_d     = xor_q;
      gap_d     = gap_q;
      outs_d    = outs_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      whistle_d = 1'b0;
      case (state_q)
         PK_HUNT: begin
            gap_d = '0;
            if (byte_valid && byte_data == PKT_HEADER) begin
               state_d = PK_PAYLOAD;
               idx_d   = 4'd1;
               xor_d   = '0;
            end
         end
         PK_PAYLOAD, PK_CHECK: begin
            if (frame_err) begin
               err_d   = 1'b1;
               state_d = PK_HUNT;
            end else if (byte_valid) begin
               gap_d = '0;
               if (state_q == PK_PAYLOAD) begin
                  // Header value is ordinary data here; no resync inside a packet
                  shadow_d[3'(idx_q - 4'd1)] = byte_data;
                  xor_d = xor_q ^ byte_data;
                  if (idx_q == 4'd8) state_d = PK_CHECK;
                  else idx_d = idx_q + 4'd1;
               end else begin
                  state_d = PK_HUNT;
                  if (byte_data == xor_q) begin
                     outs_d    = unpack_payload(shadow_q);
                     valid_d   = 1'b1;
                     whistle_d = shadow_q[7][FLAG_WHISTLE];
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end else if (gap_q == GAP_LAST) begin
               err_d   = 1'b1;
               state_d = PK_HUNT;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = PK_HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= PK_HUNT;
         idx_q     <= '0;
         shadow_q  <= '0;
         xor_q     <= '0;
         gap_q     <= '0;
         outs_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         whistle_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         xor_q     <= xor_d;
         gap_q     <= gap_d;
         outs_q    <= outs_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         whistle_q <= whistle_d;
      end
   end

   assign pl1_posx     = outs_q.pl1_posx;
   assign pl1_posy     = outs_q.pl1_posy;
   assign ball_xpos    = outs_q.ball_xpos;
   assign ball_ypos    = outs_q.ball_ypos;
   assign score_pl1    = outs_q.score_pl1;
   assign score_pl2    = outs_q.score_pl2;
   assign endgame      = outs_q.endgame;
   assign last_touch   = outs_q.last_touch;
   assign whistle_play = whistle_q;
   assign pkt_valid    = valid_q;
   assign pkt_err      = err_q;

endmodule

// File: tb/tb_game_state_rx.sv
module tb_game_state_rx;

   localparam int CPB  = 8;
   localparam int TOUT = 300;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic [11:0] pl1_posx, pl1_posy, ball_xpos, ball_ypos;
   logic [3:0] score_pl1, score_pl2;
   logic endgame, last_touch, whistle_play, pkt_valid, pkt_err;

   game_state_rx #(.CLK_HZ(80), .BAUD(10), .TIMEOUT_CLKS(TOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .pl1_posx     (pl1_posx),
      .pl1_posy     (pl1_posy),
      .ball_xpos    (ball_xpos),
      .ball_ypos    (ball_ypos),
      .score_pl1    (score_pl1),
      .score_pl2    (score_pl2),
      .endgame      (endgame),
      .last_touch   (last_touch),
      .whistle_play (whistle_play),
      .pkt_valid    (pkt_valid),
      .pkt_err      (pkt_err)
   );

   always #5 clk = ~clk;

   // Pulse counters: a 1-cycle pulse adds exactly 1
   int n_valid = 0, n_err = 0, n_wh = 0, n_both = 0;
   always @(negedge clk) begin
      if (pkt_valid) n_valid <= n_valid + 1;
      if (pkt_err) n_err <= n_err + 1;
      if (whistle_play) n_wh <= n_wh + 1;
      if (pkt_valid && pkt_err) n_both <= n_both + 1;
   end

   int tests = 0, fails = 0;
   logic [7:0] pk [0:9];
   logic [57:0] exp_out;
   int v0, e0, w0;

   typedef struct {
      logic [11:0] px, py, bx, by;
      logic [3:0]  s1, s2;
      logic [2:0]  fl;
      logic        bad_xor;
      int          ev, ee, ew;
   } vec_t;
   vec_t vecs [6];

   function automatic logic [57:0] act_out();
      return {pl1_posx, pl1_posy, ball_xpos, ball_ypos, score_pl1, score_pl2, endgame, last_touch};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic bit_time(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v, input int idle_bits);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(stop_v);
      repeat (idle_bits) bit_time(1'b1);
   endtask

   task automatic send_range(input int first, input int last, input int idle_bits);
      for (int i = first; i <= last; i++) send_byte(pk[i], 1'b1, idle_bits);
   endtask

   task automatic build(input logic [11:0] px, py, bx, by, input logic [3:0] s1, s2,
                        input logic [2:0] fl);
      pk[0] = 8'hA5;
      pk[1] = px[11:4];
      pk[2] = {px[3:0], py[11:8]};
      pk[3] = py[7:0];
      pk[4] = bx[11:4];
      pk[5] = {bx[3:0], by[11:8]};
      pk[6] = by[7:0];
      pk[7] = {s1, s2};
      pk[8] = {5'b0, fl};
      pk[9] = 8'h00;
      for (int i = 1; i <= 8; i++) pk[9] = pk[9] ^ pk[i];
   endtask

   task automatic snap();
      repeat (4) @(negedge clk);
      v0 = n_valid; e0 = n_err; w0 = n_wh;
   endtask

   task automatic chk_counts(input string nm, input int dv, input int de, input int dw);
      repeat (4) @(negedge clk);
      chk({nm, "_valid"}, 64'(n_valid - v0), 64'(dv));
      chk({nm, "_err"}, 64'(n_err - e0), 64'(de));
      chk({nm, "_whistle"}, 64'(n_wh - w0), 64'(dw));
      chk({nm, "_outs"}, 64'(act_out()), 64'(exp_out));
   endtask

   initial begin
      vecs[0] = '{12'h123, 12'h456, 12'h789, 12'hABC, 4'd3, 4'd5, 3'b101, 1'b0, 1, 0, 0};
      vecs[1] = '{12'h123, 12'h456, 12'h789, 12'hABC, 4'd3, 4'd5, 3'b010, 1'b0, 1, 0, 1};
      vecs[2] = '{12'h123, 12'h456, 12'h789, 12'hABC, 4'd3, 4'd5, 3'b000, 1'b0, 1, 0, 0};
      vecs[3] = '{12'h321, 12'h654, 12'h987, 12'hCBA, 4'd7, 4'd9, 3'b111, 1'b1, 0, 1, 0};
      vecs[4] = '{12'h321, 12'h654, 12'h987, 12'hCBA, 4'd7, 4'd9, 3'b111, 1'b0, 1, 0, 1};
      vecs[5] = '{12'hA50, 12'h0A5, 12'h5A5, 12'hA5A, 4'hA, 4'h5, 3'b100, 1'b0, 1, 0, 0};

      // Reset state
      exp_out = '0;
      repeat (4) @(negedge clk);
      chk("reset_outs", 64'(act_out()), 64'(0));
      chk("reset_pulses", 64'({whistle_play, pkt_valid, pkt_err}), 64'(0));
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Table-driven packets
      for (int k = 0; k < 6; k++) begin
         build(vecs[k].px, vecs[k].py, vecs[k].bx, vecs[k].by, vecs[k].s1, vecs[k].s2, vecs[k].fl);
         if (vecs[k].bad_xor) pk[9] = pk[9] ^ 8'h01;
         snap();
         send_range(0, 9, 2);
         if (vecs[k].ev == 1)
            exp_out = {vecs[k].px, vecs[k].py, vecs[k].bx, vecs[k].by, vecs[k].s1, vecs[k].s2,
                       vecs[k].fl[2], vecs[k].fl[0]};
         chk_counts($sformatf("vec%0d", k), vecs[k].ev, vecs[k].ee, vecs[k].ew);
      end

      // Garbage before a valid packet
      snap();
      send_byte(8'h00, 1'b1, 2);
      send_byte(8'h5A, 1'b1, 2);
      build(12'h123, 12'h456, 12'h789, 12'hABC, 4'd3, 4'd5, 3'b101);
      send_range(0, 9, 2);
      exp_out = {12'h123, 12'h456, 12'h789, 12'hABC, 4'd3, 4'd5, 1'b1, 1'b1};
      chk_counts("garbage", 1, 0, 0);

      // Inter-byte timeout, then recovery
      snap();
      build(12'h111, 12'h222, 12'h333, 12'h444, 4'd1, 4'd2, 3'b001);
      send_range(0, 4, 2);
      repeat (TOUT + 10) @(negedge clk);
      chk_counts("timeout", 0, 1, 0);
      snap();
      send_range(0, 9, 2);
      exp_out = {12'h111, 12'h222, 12'h333, 12'h444, 4'd1, 4'd2, 1'b0, 1'b1};
      chk_counts("after_timeout", 1, 0, 0);

      // Bad stop bit on B3
      snap();
      build(12'h0F0, 12'h0E0, 12'h0D0, 12'h0C0, 4'd4, 4'd4, 3'b000);
      send_range(0, 2, 2);
      send_byte(pk[3], 1'b0, 3);
      chk_counts("frame_err", 0, 1, 0);
      snap();
      send_range(0, 9, 2);
      exp_out = {12'h0F0, 12'h0E0, 12'h0D0, 12'h0C0, 4'd4, 4'd4, 1'b0, 1'b0};
      chk_counts("after_frame_err", 1, 0, 0);

      // Reset in the middle of B5
      snap();
      build(12'h123, 12'h456, 12'h789, 12'hABC, 4'd3, 4'd5, 3'b101);
      send_range(0, 4, 2);
      bit_time(1'b0);
      bit_time(pk[5][0]);
      bit_time(pk[5][1]);
      rx = pk[5][2];
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      exp_out = '0;
      chk("midreset_outs", 64'(act_out()), 64'(0));
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 3; i < 8; i++) bit_time(pk[5][i]);
      bit_time(1'b1);
      repeat (12) bit_time(1'b1);
      send_range(6, 9, 12);
      chk_counts("midreset_tail", 0, 0, 0);
      snap();
      send_range(0, 9, 2);
      exp_out = {12'h123, 12'h456, 12'h789, 12'hABC, 4'd3, 4'd5, 1'b1, 1'b1};
      chk_counts("after_reset", 1, 0, 0);

      // Short low glitch in the idle gap inside a packet must not create a byte
      snap();
      build(12'h321, 12'h654, 12'h987, 12'hCBA, 4'd7, 4'd9, 3'b010);
      send_range(0, 4, 2);
      rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx = 1'b1;
      repeat (3) bit_time(1'b1);
      send_range(5, 9, 2);
      exp_out = {12'h321, 12'h654, 12'h987, 12'hCBA, 4'd7, 4'd9, 1'b0, 1'b0};
      chk_counts("glitch", 1, 0, 1);

      chk("valid_err_overlap", 64'(n_both), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
